// File: rtl/tof_counter_if.sv
// Result/handshake bundle between the time-of-flight counter and its control/downstream logic.
// master is the counter side, slave is the start source and result consumer.
interface tof_counter_if #(
  parameter int CNT_W = 16
) ();
  logic             start_pulse;
  logic             echo_in;
  logic             result_ack;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             timeout;
  logic             busy;
  logic             start_miss;

  modport master (
    input  start_pulse, echo_in, result_ack,
    output result, result_valid, timeout, busy, start_miss
  );

  modport slave (
    output start_pulse, echo_in, result_ack,
    input  result, result_valid, timeout, busy, start_miss
  );
endinterface

// File: rtl/tof_counter.sv
// Time-of-flight counter: counts clk cycles from start to the first synchronized echo rising edge,
// with a blanking window after start and a timeout at MAX_COUNT.
module tof_counter #(
  parameter int CNT_W        = 16,
  parameter int BLANK_CYCLES = 8,
  parameter int MAX_COUNT    = 65535
) (
  input logic           clk,
  input logic           rst,
  tof_counter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BLANK, MEASURE, HOLD} state_t;

  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] MAX_LIM   = CNT_W'(MAX_COUNT);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [CNT_W-1:0] result_q, result_next;
  logic             timeout_q, timeout_next;
  logic             valid_q, valid_next;
  logic             busy_q, busy_next;
  logic             miss_q, miss_next;
  logic             echo_s1, echo_s2, echo_s3;
  logic             rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      miss_q    <= 1'b0;
      echo_s1   <= 1'b0;
      echo_s2   <= 1'b0;
      echo_s3   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      result_q  <= result_next;
      timeout_q <= timeout_next;
      valid_q   <= valid_next;
      busy_q    <= busy_next;
      miss_q    <= miss_next;
      echo_s1   <= bus.echo_in;
      echo_s2   <= echo_s1;
      echo_s3   <= echo_s2;
    end
  end

  assign rise    = echo_s2 & ~echo_s3;
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    result_next  = result_q;
    timeout_next = timeout_q;
    valid_next   = valid_q;
    miss_next    = bus.start_pulse && (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.start_pulse) begin
          cnt_next = '0;
          if (BLANK_CYCLES == 0) state_next = MEASURE;
          else                   state_next = BLANK;
        end
      end
      BLANK: begin
        cnt_next = cnt_inc;
        if (cnt_inc == BLANK_LIM) state_next = MEASURE;
      end
      MEASURE: begin
        // Echo is checked before the limit so a coincident edge still reports a real return
        if (rise) begin
          result_next  = cnt;
          timeout_next = 1'b0;
          valid_next   = 1'b1;
          state_next   = HOLD;
        end else if (cnt == MAX_LIM) begin
          result_next  = MAX_LIM;
          timeout_next = 1'b1;
          valid_next   = 1'b1;
          state_next   = HOLD;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HOLD: begin
        if (bus.result_ack) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == BLANK) || (state_next == MEASURE);
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.busy         = busy_q;
  assign bus.start_miss   = miss_q;
endmodule

// File: tb/tb_tof_counter.sv
// Directed bench for tof_counter: blanking, timeout, dropped starts, reset abort, zero-blank variant.
module tb_tof_counter;
  localparam int CNT_W = 16;
  localparam int MAXC  = 200;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tof_counter_if #(.CNT_W(CNT_W)) bus_a ();
  tof_counter_if #(.CNT_W(CNT_W)) bus_b ();

  tof_counter #(.CNT_W(CNT_W), .BLANK_CYCLES(8), .MAX_COUNT(MAXC)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  tof_counter #(.CNT_W(CNT_W), .BLANK_CYCLES(0), .MAX_COUNT(MAXC)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  // Every stimulus step lands 1 time unit after a rising edge, so outputs are settled
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_a();
    bus_a.start_pulse = 1'b1;
    tick_n(1);
    bus_a.start_pulse = 1'b0;
  endtask

  task automatic ack_a();
    bus_a.result_ack = 1'b1;
    tick_n(1);
    bus_a.result_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick_n(3);
    rst = 1'b0;
    tick_n(1);
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", bus_a.result_valid); end
    checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %0b want 0", bus_a.timeout); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", bus_a.busy); end
    checks++; if (bus_a.start_miss !== 1'b0) begin errors++; $display("[TB] FAIL reset_miss got %0b want 0", bus_a.start_miss); end
    checks++; if (bus_a.result !== 16'd0) begin errors++; $display("[TB] FAIL reset_result got %0d want 0", bus_a.result); end
  endtask

  task automatic test_basic();
    start_a();
    tick_n(98);
    bus_a.echo_in = 1'b1;
    tick_n(2);
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %0b want 0", bus_a.result_valid); end
    tick_n(1);
    checks++; if (bus_a.result_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %0b want 1", bus_a.result_valid); end
    checks++; if (bus_a.result !== 16'd100) begin errors++; $display("[TB] FAIL basic_result got %0d want 100", bus_a.result); end
    checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout got %0b want 0", bus_a.timeout); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy got %0b want 0", bus_a.busy); end
    tick_n(3);
    checks++; if (bus_a.result_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_hold_valid got %0b want 1", bus_a.result_valid); end
    ack_a();
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack_valid got %0b want 0", bus_a.result_valid); end
    checks++; if (bus_a.result !== 16'd100) begin errors++; $display("[TB] FAIL basic_post_ack_result got %0d want 100", bus_a.result); end
    bus_a.echo_in = 1'b0;
    tick_n(4);
  endtask

  task automatic test_blanking();
    start_a();
    tick_n(2);
    bus_a.echo_in = 1'b1;
    tick_n(3);
    bus_a.echo_in = 1'b0;
    tick_n(33);
    bus_a.echo_in = 1'b1;
    tick_n(2);
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("[TB] FAIL blank_busy got %0b want 1", bus_a.busy); end
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL blank_early_valid got %0b want 0", bus_a.result_valid); end
    tick_n(1);
    checks++; if (bus_a.result_valid !== 1'b1) begin errors++; $display("[TB] FAIL blank_valid got %0b want 1", bus_a.result_valid); end
    checks++; if (bus_a.result !== 16'd40) begin errors++; $display("[TB] FAIL blank_result got %0d want 40", bus_a.result); end
    ack_a();
    bus_a.echo_in = 1'b0;
    tick_n(4);
  endtask

  task automatic test_timeout();
    start_a();
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("[TB] FAIL to_busy_start got %0b want 1", bus_a.busy); end
    tick_n(200);
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("[TB] FAIL to_busy_end got %0b want 1", bus_a.busy); end
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_early_valid got %0b want 0", bus_a.result_valid); end
    tick_n(1);
    checks++; if (bus_a.result_valid !== 1'b1) begin errors++; $display("[TB] FAIL to_valid got %0b want 1", bus_a.result_valid); end
    checks++; if (bus_a.result !== 16'd200) begin errors++; $display("[TB] FAIL to_result got %0d want 200", bus_a.result); end
    checks++; if (bus_a.timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_flag got %0b want 1", bus_a.timeout); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL to_busy_done got %0b want 0", bus_a.busy); end
    ack_a();
    tick_n(2);
  endtask

  task automatic test_back_to_back();
    start_a();
    tick_n(4);
    bus_a.start_pulse = 1'b1;
    tick_n(1);
    bus_a.start_pulse = 1'b0;
    checks++; if (bus_a.start_miss !== 1'b1) begin errors++; $display("[TB] FAIL miss_busy got %0b want 1", bus_a.start_miss); end
    tick_n(1);
    checks++; if (bus_a.start_miss !== 1'b0) begin errors++; $display("[TB] FAIL miss_busy_pulse got %0b want 0", bus_a.start_miss); end
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("[TB] FAIL miss_still_busy got %0b want 1", bus_a.busy); end
    tick_n(12);
    bus_a.echo_in = 1'b1;
    tick_n(3);
    checks++; if (bus_a.result !== 16'd20) begin errors++; $display("[TB] FAIL miss_result got %0d want 20", bus_a.result); end
    tick_n(1);
    bus_a.start_pulse = 1'b1;
    bus_a.result_ack  = 1'b1;
    tick_n(1);
    bus_a.start_pulse = 1'b0;
    bus_a.result_ack  = 1'b0;
    checks++; if (bus_a.start_miss !== 1'b1) begin errors++; $display("[TB] FAIL miss_hold got %0b want 1", bus_a.start_miss); end
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL miss_hold_valid got %0b want 0", bus_a.result_valid); end
    checks++; if (bus_a.result !== 16'd20) begin errors++; $display("[TB] FAIL miss_hold_result got %0d want 20", bus_a.result); end
    tick_n(1);
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL miss_dropped_busy got %0b want 0", bus_a.busy); end
    bus_a.echo_in = 1'b0;
    tick_n(4);
    start_a();
    tick_n(28);
    bus_a.echo_in = 1'b1;
    tick_n(3);
    checks++; if (bus_a.result_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid got %0b want 1", bus_a.result_valid); end
    checks++; if (bus_a.result !== 16'd30) begin errors++; $display("[TB] FAIL b2b_result got %0d want 30", bus_a.result); end
    ack_a();
    bus_a.echo_in = 1'b0;
    tick_n(4);
  endtask

  task automatic test_reset_abort();
    start_a();
    tick_n(50);
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b want 0", bus_a.busy); end
    checks++; if (bus_a.result !== 16'd0) begin errors++; $display("[TB] FAIL abort_result got %0d want 0", bus_a.result); end
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid got %0b want 0", bus_a.result_valid); end
    bus_a.echo_in = 1'b1;
    tick_n(6);
    checks++; if (bus_a.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_late_echo got %0b want 0", bus_a.result_valid); end
    bus_a.echo_in = 1'b0;
    tick_n(4);
    start_a();
    tick_n(58);
    bus_a.echo_in = 1'b1;
    tick_n(3);
    checks++; if (bus_a.result !== 16'd60) begin errors++; $display("[TB] FAIL abort_fresh_result got %0d want 60", bus_a.result); end
    checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("[TB] FAIL abort_fresh_timeout got %0b want 0", bus_a.timeout); end
    ack_a();
    bus_a.echo_in = 1'b0;
    tick_n(4);
  endtask

  task automatic test_echo_level();
    bus_a.echo_in = 1'b1;
    tick_n(5);
    start_a();
    tick_n(201);
    checks++; if (bus_a.result !== 16'd200) begin errors++; $display("[TB] FAIL level_result got %0d want 200", bus_a.result); end
    checks++; if (bus_a.timeout !== 1'b1) begin errors++; $display("[TB] FAIL level_timeout got %0b want 1", bus_a.timeout); end
    ack_a();
    bus_a.echo_in = 1'b0;
    tick_n(4);
  endtask

  task automatic test_zero_blank();
    bus_b.echo_in     = 1'b1;
    bus_b.start_pulse = 1'b1;
    tick_n(1);
    bus_b.start_pulse = 1'b0;
    checks++; if (bus_b.busy !== 1'b1) begin errors++; $display("[TB] FAIL zb_busy got %0b want 1", bus_b.busy); end
    tick_n(1);
    checks++; if (bus_b.result_valid !== 1'b0) begin errors++; $display("[TB] FAIL zb_early_valid got %0b want 0", bus_b.result_valid); end
    tick_n(1);
    checks++; if (bus_b.result_valid !== 1'b1) begin errors++; $display("[TB] FAIL zb_valid got %0b want 1", bus_b.result_valid); end
    checks++; if (bus_b.result !== 16'd1) begin errors++; $display("[TB] FAIL zb_result got %0d want 1", bus_b.result); end
    checks++; if (bus_b.timeout !== 1'b0) begin errors++; $display("[TB] FAIL zb_timeout got %0b want 0", bus_b.timeout); end
  endtask

  initial begin
    bus_a.start_pulse = 1'b0; bus_a.echo_in = 1'b0; bus_a.result_ack = 1'b0;
    bus_b.start_pulse = 1'b0; bus_b.echo_in = 1'b0; bus_b.result_ack = 1'b0;
    test_reset();
    test_basic();
    test_blanking();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    test_echo_level();
    test_zero_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
